// File: rtl/or1200_dcpu_responder_pkg.sv
// Shared types and constants for the or1200 data-side responder and its byte-lane merge.
package or1200_dcpu_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int CNT_W = 4;
  localparam int LANES = 4;

  // Lane numbering is big-endian: LANE0 is bits 31:24, LANE3 is bits 7:0.
  localparam int LANE0 = 0;
  localparam int LANE1 = 1;
  localparam int LANE2 = 2;
  localparam int LANE3 = 3;

  function automatic int lane_lo(input int lane);
    return 24 - 8 * lane;
  endfunction

  function automatic int lane_sel(input int lane);
    return 3 - lane;
  endfunction

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [3:0]  tag;
    logic [31:0] dat;
    logic        in_range;
  } req_t;

endpackage

// File: rtl/or1200_dcpu_bytemerge.sv
// Combinational byte-enable merge of new store data into an existing 32-bit word.
module or1200_dcpu_bytemerge
  import or1200_dcpu_responder_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  input  logic [3:0]  sel,
  output logic [31:0] merged
);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    localparam int LO = lane_lo(gi);
    localparam int SB = lane_sel(gi);
    assign merged[LO +: 8] = sel[SB] ? new_data[LO +: 8] : old_word[LO +: 8];
  end

endmodule

// File: rtl/or1200_dcpu_responder.sv
// Data-port responder for the or1200 CPU: byte-enabled word RAM with programmable
// response latency, stall injection and out-of-window bus errors.
module or1200_dcpu_responder
  import or1200_dcpu_responder_pkg::*;
#(
  parameter int          AW        = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          LATENCY   = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dcpu_cycstb_i,
  input  logic        dcpu_we_i,
  input  logic [3:0]  dcpu_sel_i,
  input  logic [3:0]  dcpu_tag_i,
  input  logic [31:0] dcpu_adr_i,
  input  logic [31:0] dcpu_dat_i,
  input  logic        stall_i,
  output logic        dcpu_ack_o,
  output logic        dcpu_err_o,
  output logic        dcpu_rty_o,
  output logic [3:0]  dcpu_tag_o,
  output logic [31:0] dcpu_dat_o
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 2);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  req_t             req_reg, req_next;
  logic [AW-1:0]    idx_reg, idx_next;

  logic [31:0] mem [2**AW];
  logic [31:0] rd_word_reg;
  logic [31:0] wr_word;
  logic        mem_we;
  logic        in_range_in;
  logic        unused_adr_bits;

  // Sub-word alignment arrives through sel, so the low address bits carry nothing.
  assign unused_adr_bits = ^dcpu_adr_i[1:0];
  assign in_range_in     = (dcpu_adr_i[31:AW+2] == BASE_ADDR[31:AW+2]);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      req_reg   <= '0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      req_reg   <= req_next;
      idx_reg   <= idx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    req_next   = req_reg;
    idx_next   = idx_reg;
    case (state_reg)
      ST_IDLE: begin
        if (dcpu_cycstb_i) begin
          req_next = '{we: dcpu_we_i, sel: dcpu_sel_i, tag: dcpu_tag_i,
                       dat: dcpu_dat_i, in_range: in_range_in};
          idx_next = dcpu_adr_i[AW+1:2];
          if (LATENCY == 1) begin
            state_next = ST_RESP;
          end else begin
            cnt_next   = CNT_INIT;
            state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!dcpu_cycstb_i) begin
          state_next = ST_IDLE;
        end else if (!stall_i) begin
          if (cnt_reg == '0) begin
            state_next = ST_RESP;
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    dcpu_ack_o = 1'b0;
    dcpu_err_o = 1'b0;
    dcpu_tag_o = '0;
    dcpu_dat_o = '0;
    if (state_reg == ST_RESP) begin
      dcpu_ack_o = req_reg.in_range;
      dcpu_err_o = !req_reg.in_range;
      dcpu_tag_o = req_reg.tag;
      if (req_reg.in_range && !req_reg.we) begin
        dcpu_dat_o = rd_word_reg;
      end
    end
  end

  assign dcpu_rty_o = 1'b0;

  or1200_dcpu_bytemerge u_merge (
    .old_word (rd_word_reg),
    .new_data (req_reg.dat),
    .sel      (req_reg.sel),
    .merged   (wr_word)
  );

  assign mem_we = (state_reg == ST_RESP) && req_reg.in_range && req_reg.we;

  // The word is read on the edge entering RESP; it serves both the load data and
  // the old value for a partial store committed on the following edge.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[idx_reg] <= wr_word;
    end
    if (state_next == ST_RESP) begin
      rd_word_reg <= mem[idx_next];
    end
  end

endmodule

// File: tb/tb_or1200_dcpu_responder.sv
// Directed bench: three responders (LATENCY 1, 3, 4) exercised through a linear step list.
module tb_or1200_dcpu_responder;

  logic        clock;
  logic        reset;
  logic        cyc   [3];
  logic        we    [3];
  logic        stall [3];
  logic [3:0]  sel   [3];
  logic [3:0]  tagi  [3];
  logic [31:0] adr   [3];
  logic [31:0] dati  [3];
  logic        ack   [3];
  logic        err   [3];
  logic        rty   [3];
  logic [3:0]  tago  [3];
  logic [31:0] dato  [3];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    or1200_dcpu_responder #(
      .AW        (10),
      .BASE_ADDR (32'h0000_0000),
      .LATENCY   ((gi == 0) ? 1 : ((gi == 1) ? 3 : 4))
    ) u_dut (
      .clock         (clock),
      .reset         (reset),
      .dcpu_cycstb_i (cyc[gi]),
      .dcpu_we_i     (we[gi]),
      .dcpu_sel_i    (sel[gi]),
      .dcpu_tag_i    (tagi[gi]),
      .dcpu_adr_i    (adr[gi]),
      .dcpu_dat_i    (dati[gi]),
      .stall_i       (stall[gi]),
      .dcpu_ack_o    (ack[gi]),
      .dcpu_err_o    (err[gi]),
      .dcpu_rty_o    (rty[gi]),
      .dcpu_tag_o    (tago[gi]),
      .dcpu_dat_o    (dato[gi])
    );
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic clear_inputs(input int k);
    cyc[k] = 0; we[k] = 0; stall[k] = 0; sel[k] = 0;
    tagi[k] = 0; adr[k] = 0; dati[k] = 0;
  endtask

  // Issue one request, hold cycstb until a response, scramble the other inputs
  // after acceptance and raise stall for the first nstall waiting cycles.
  task automatic run_req(input int k, input bit w, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] d,
                         input logic [3:0] t, input int nstall,
                         output int lat, output logic r_ack, output logic r_err,
                         output logic [31:0] r_dat, output logic [3:0] r_tag,
                         output logic after, output bit quiet);
    @(negedge clock);
    cyc[k] = 1; we[k] = w; adr[k] = a; sel[k] = s; dati[k] = d; tagi[k] = t; stall[k] = 0;
    lat = -1; r_ack = 0; r_err = 0; r_dat = '0; r_tag = '0; quiet = 1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (ack[k] || err[k]) begin
        lat = n; r_ack = ack[k]; r_err = err[k]; r_dat = dato[k]; r_tag = tago[k];
        break;
      end
      if (dato[k] !== 32'h0) quiet = 0;
      we[k] = ~w; adr[k] = a ^ 32'h0000_0FF0; sel[k] = ~s; dati[k] = ~d; tagi[k] = ~t;
      stall[k] = (n <= nstall);
    end
    clear_inputs(k);
    @(negedge clock);
    after = ack[k] | err[k];
    $display("req dut%0d we=%0d adr=%h sel=%h tag=%h -> lat=%0d ack=%0d err=%0d dat=%h tag=%h",
             k, w, a, s, t, lat, r_ack, r_err, r_dat, r_tag);
  endtask

  int          lat;
  logic        r_ack, r_err, after;
  logic [31:0] r_dat;
  logic [3:0]  r_tag;
  bit          quiet;
  bit          seen;

  initial begin
    reset = 0;
    for (int k = 0; k < 3; k++) clear_inputs(k);
    repeat (2) @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      chk("reset_ack", ack[k], 1'b0);
      chk("reset_err", err[k], 1'b0);
      chk("reset_rty", rty[k], 1'b0);
      chk("reset_dat", dato[k], 32'h0);
      chk("reset_tag", tago[k], 4'h0);
    end
    reset = 1;

    // LATENCY 1 store then load
    run_req(0, 1, 32'h10, 4'hF, 32'hDEADBEEF, 4'h3, 0, lat, r_ack, r_err, r_dat, r_tag, after, quiet);
    chk("l1_st_lat", lat, 1);
    chk("l1_st_ack", r_ack, 1'b1);
    chk("l1_st_tag", r_tag, 4'h3);
    chk("l1_st_dat0", r_dat, 32'h0);
    chk("l1_st_pulse", after, 1'b0);
    run_req(0, 0, 32'h10, 4'hF, 32'h0, 4'h5, 0, lat, r_ack, r_err, r_dat, r_tag, after, quiet);
    chk("l1_ld_lat", lat, 1);
    chk("l1_ld_dat", r_dat, 32'hDEADBEEF);
    chk("l1_ld_tag", r_tag, 4'h5);

    // Byte lanes
    run_req(0, 1, 32'h20, 4'hF, 32'hAABBCCDD, 4'h1, 0, lat, r_ack, r_err, r_dat, r_tag, after, quiet);
    run_req(0, 1, 32'h20, 4'b0100, 32'h11223344, 4'h2, 0, lat, r_ack, r_err, r_dat, r_tag, after, quiet);
    chk("lane_st_ack", r_ack, 1'b1);
    run_req(0, 0, 32'h20, 4'hF, 32'h0, 4'h4, 0, lat, r_ack, r_err, r_dat, r_tag, after, quiet);
    chk("lane_ld_dat", r_dat, 32'hAA22CCDD);
    run_req(0, 1, 32'h20, 4'h0, 32'hFFFFFFFF, 4'h6, 0, lat, r_ack, r_err, r_dat, r_tag, after, quiet);
    chk("sel0_ack", r_ack, 1'b1);
    run_req(0, 0, 32'h23, 4'h1, 32'h0, 4'h7, 0, lat, r_ack, r_err, r_dat, r_tag, after, quiet);
    chk("sel0_unaligned_ld", r_dat, 32'hAA22CCDD);

    // LATENCY 4, then with two stalled wait cycles
    run_req(2, 1, 32'h40, 4'hF, 32'h12345678, 4'h8, 0, lat, r_ack, r_err, r_dat, r_tag, after, quiet);
    chk("l4_st_lat", lat, 4);
    chk("l4_st_ack", r_ack, 1'b1);
    run_req(2, 0, 32'h40, 4'hF, 32'h0, 4'hA, 2, lat, r_ack, r_err, r_dat, r_tag, after, quiet);
    chk("l4_stall_lat", lat, 6);
    chk("l4_stall_dat", r_dat, 32'h12345678);
    chk("l4_stall_tag", r_tag, 4'hA);
    chk("l4_stall_pulse", after, 1'b0);
    chk("l4_wait_dat0", quiet, 1'b1);

    // Out of range and top-of-window boundary
    run_req(0, 1, 32'h0, 4'hF, 32'hCAFEF00D, 4'h1, 0, lat, r_ack, r_err, r_dat, r_tag, after, quiet);
    run_req(0, 0, 32'h1000, 4'hF, 32'h0, 4'hB, 0, lat, r_ack, r_err, r_dat, r_tag, after, quiet);
    chk("oor_ld_lat", lat, 1);
    chk("oor_ld_err", r_err, 1'b1);
    chk("oor_ld_ack", r_ack, 1'b0);
    chk("oor_ld_dat", r_dat, 32'h0);
    chk("oor_ld_tag", r_tag, 4'hB);
    run_req(0, 1, 32'h1000, 4'hF, 32'h0, 4'hC, 0, lat, r_ack, r_err, r_dat, r_tag, after, quiet);
    chk("oor_st_err", r_err, 1'b1);
    chk("oor_st_pulse", after, 1'b0);
    run_req(0, 0, 32'h0, 4'hF, 32'h0, 4'hD, 0, lat, r_ack, r_err, r_dat, r_tag, after, quiet);
    chk("oor_mem0_kept", r_dat, 32'hCAFEF00D);
    run_req(0, 1, 32'hFFC, 4'hF, 32'h0BADBEEF, 4'h2, 0, lat, r_ack, r_err, r_dat, r_tag, after, quiet);
    chk("top_st_ack", r_ack, 1'b1);
    run_req(0, 0, 32'hFFC, 4'hF, 32'h0, 4'h3, 0, lat, r_ack, r_err, r_dat, r_tag, after, quiet);
    chk("top_ld_dat", r_dat, 32'h0BADBEEF);

    // Abort in WAIT (LATENCY 3)
    run_req(1, 1, 32'h30, 4'hF, 32'h55555555, 4'h1, 0, lat, r_ack, r_err, r_dat, r_tag, after, quiet);
    chk("l3_st_lat", lat, 3);
    @(negedge clock);
    cyc[1] = 1; we[1] = 1; adr[1] = 32'h30; sel[1] = 4'hF; dati[1] = 32'hA5A5A5A5; tagi[1] = 4'h2;
    @(negedge clock);
    clear_inputs(1);
    seen = 0;
    repeat (6) begin
      @(negedge clock);
      if (ack[1] || err[1]) seen = 1;
    end
    $display("abort dut1 adr=00000030 -> response_seen=%0d", seen);
    chk("abort_no_resp", seen, 1'b0);
    run_req(1, 0, 32'h30, 4'hF, 32'h0, 4'h3, 0, lat, r_ack, r_err, r_dat, r_tag, after, quiet);
    chk("abort_old_data", r_dat, 32'h55555555);
    chk("abort_ld_lat", lat, 3);

    // Reset while a store waits (LATENCY 4)
    @(negedge clock);
    cyc[2] = 1; we[2] = 1; adr[2] = 32'h40; sel[2] = 4'hF; dati[2] = 32'h0; tagi[2] = 4'h9;
    @(negedge clock);
    reset = 0;
    #1;
    chk("rst_wait_ack", ack[2], 1'b0);
    chk("rst_wait_err", err[2], 1'b0);
    chk("rst_wait_tag", tago[2], 4'h0);
    chk("rst_wait_dat", dato[2], 32'h0);
    clear_inputs(2);
    @(negedge clock);
    reset = 1;
    $display("reset in WAIT dut2 applied and released");
    run_req(2, 0, 32'h40, 4'hF, 32'h0, 4'h4, 0, lat, r_ack, r_err, r_dat, r_tag, after, quiet);
    chk("rst_wait_ld_lat", lat, 4);
    chk("rst_wait_ld_dat", r_dat, 32'h12345678);

    // Reset during the response cycle of a store (LATENCY 1)
    @(negedge clock);
    cyc[0] = 1; we[0] = 1; adr[0] = 32'h10; sel[0] = 4'hF; dati[0] = 32'h0; tagi[0] = 4'h7;
    @(negedge clock);
    chk("rst_resp_pre_ack", ack[0], 1'b1);
    chk("rst_resp_pre_tag", tago[0], 4'h7);
    reset = 0;
    #1;
    chk("rst_resp_ack", ack[0], 1'b0);
    chk("rst_resp_tag", tago[0], 4'h0);
    clear_inputs(0);
    @(negedge clock);
    reset = 1;
    $display("reset in RESP dut0 applied and released");
    run_req(0, 0, 32'h10, 4'hF, 32'h0, 4'h6, 0, lat, r_ack, r_err, r_dat, r_tag, after, quiet);
    chk("rst_resp_no_write", r_dat, 32'hDEADBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/or1200_dcpu_responder.md
Name: or1200_dcpu_responder

Overview:
Data-side memory responder for the or1200 CPU data port (dcpu_*). It completes CPU load and store requests from a word-organised, byte-enabled RAM model, with a programmable response latency and a stall input. It sits between the CPU's LSU and the formal/simulation harness, and supplies the dcpu_dat_i / ack stream that the CPU-side property checker monitors.

Parameters:
AW, 10, word-address width; memory depth is 2^AW 32-bit words.
BASE_ADDR, 32'h0000_0000, byte base address of the RAM window; must be aligned to 4*2^AW.
LATENCY, 1, cycles from request acceptance to response; legal range 1..15.

Ports:
clock  in  1  single clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset.
dcpu_cycstb_i  in  1  CPU request valid.
dcpu_we_i  in  1  1 = store, 0 = load.
dcpu_sel_i  in  4  byte enables; sel[3] maps to bits 31:24 (big-endian).
dcpu_tag_i  in  4  request tag.
dcpu_adr_i  in  32  byte address.
dcpu_dat_i  in  32  store data.
stall_i  in  1  harness-driven wait injection.
dcpu_ack_o  out  1  successful completion, one-cycle pulse.
dcpu_err_o  out  1  bus error, one-cycle pulse.
dcpu_rty_o  out  1  retry; tied to 0.
dcpu_tag_o  out  4  tag captured at acceptance, valid with ack or err.
dcpu_dat_o  out  32  load data; valid only in a load ack cycle.

Behaviour:
- Reset state: state = IDLE, ack/err/rty = 0, dat_o = 0, tag_o = 0, counter = 0.
- Reset does not clear memory. Memory is zero-initialised at time 0.
- Reset asserted mid-request aborts the request immediately: no write, no response.
- State machine has three states: IDLE, WAIT, RESP.
- IDLE:
  - cycstb_i = 1 captures adr, we, sel, tag, dat and the in_range flag.
  - If LATENCY = 1, next state is RESP. Otherwise counter = LATENCY-2 and next state is WAIT.
  - stall_i is ignored in IDLE.
- WAIT:
  - If cycstb_i = 0, the request is aborted: return to IDLE, no write.
  - Else if stall_i = 1, hold the counter.
  - Else if counter = 0, go to RESP; otherwise decrement the counter.
- RESP:
  - Moore outputs: ack_o = in_range, err_o = !in_range, tag_o = captured tag.
  - Next state is always IDLE. The earliest next acceptance is the cycle after RESP.
- Latency: a request accepted in cycle t with no stalls responds in cycle t+LATENCY. Each stalled WAIT cycle adds exactly one cycle.
- Address decode:
  - in_range = (adr[31:AW+2] == BASE_ADDR[31:AW+2]).
  - Word index = adr[AW+1:2]. adr[1:0] is ignored; the CPU conveys alignment through sel.
- Load:
  - In the RESP cycle with in_range = 1, dat_o = mem[index], full word regardless of sel. The CPU extracts lanes.
  - In all other cycles dat_o = 0.
- Store:
  - The write commits on the RESP clock edge, only if in_range = 1.
  - Only lanes with sel bit = 1 are updated.
  - sel = 0 gives an ack with no memory change.
- Out-of-range request: err pulse, no write, dat_o = 0.
- Captured fields are used for the whole request. Changes on the CPU inputs after acceptance are ignored, apart from cycstb drop in WAIT.
- A load in RESP to the same word as a store committing on that edge cannot occur: one request at a time.

Decomposition:
- Shared defines file or1200_dcpu_resp_defines.v holds:
  - state encodings (IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2);
  - lane constants (LANE0 = bits 31:24 … LANE3 = bits 7:0);
  - the counter width (4).
- One sub-module, or1200_dcpu_bytemerge: combinational merge of old word, new data and sel into the write word. It is reusable for a future icpu-side RAM.

Test Plan:
- LATENCY = 1: store adr 0x10, sel 4'hF, dat 0xDEADBEEF, tag 3. Then load 0x10 → ack one cycle after each acceptance, tag_o = 3 on the store, load dat_o = 0xDEADBEEF.
- Byte lanes: store 0xAABBCCDD to 0x20 with sel 4'hF, then store 0x11223344 with sel 4'b0100, then load 0x20 → 0xAA22CCDD.
- LATENCY = 4 with stall_i high for 2 WAIT cycles → ack at t+6, exactly one cycle wide.
- Out of range: BASE_ADDR = 0, AW = 10, load at 0x0000_1000 → err = 1 and ack = 0 at t+LATENCY, dat_o = 0. A following store to 0x1000 leaves mem[0] unchanged.
- Abort: LATENCY = 3, store accepted, cycstb drops in WAIT → no ack/err; a later load shows the old data.
- Async reset: assert reset low in WAIT → outputs 0 in the same cycle, state IDLE. After release, a new load returns the contents from before reset.
